// File: rtl/sram_march_bist.sv
// March C- self-test engine for one single-port SRAM macro driven through its BIST port.
// Runs w0, up(r0,w1), up(r1,w0), down(r0,w1), down(r1,w0), up(r0), one operation per cycle.
// It stops at the first read mismatch and reports the failing address and data.
module sram_march_bist #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic                  bist_en,
  output logic                  bist_men,
  output logic                  bist_wen,
  output logic                  bist_ren,
  output logic [ADDR_WIDTH-1:0] bist_addr,
  output logic [DATA_WIDTH-1:0] bist_din,
  output logic [DATA_WIDTH-1:0] bist_bm,
  input  logic [DATA_WIDTH-1:0] bist_dout
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = '0;
  localparam logic [DATA_WIDTH-1:0] DATA_ONES = '1;

  typedef enum logic [3:0] {
    S_IDLE, S_W0, S_UP_R0W1, S_UP_R1W0, S_DN_R0W1, S_DN_R1W0, S_R0, S_DRAIN, S_DONE
  } state_e;

  // Sequencer: element, address and read/write phase of the operation driven this cycle
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wr_phase_q, wr_phase_d;

  // Registered outputs
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  en_q;
  logic                  men_q, men_d;
  logic                  wen_q, wen_d;
  logic                  ren_q, ren_d;
  logic [ADDR_WIDTH-1:0] baddr_q, baddr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic [DATA_WIDTH-1:0] bm_q, bm_d;
  logic                  exp_ones_q, exp_ones_d;

  // Compare pipeline and failure capture
  logic                  cmp_valid_q;
  logic [DATA_WIDTH-1:0] cmp_exp_q;
  logic [ADDR_WIDTH-1:0] cmp_addr_q;
  logic                  fail_q;
  logic [ADDR_WIDTH-1:0] fail_addr_q;
  logic [DATA_WIDTH-1:0] fail_data_q;

  logic mismatch_c;
  logic start_ok_c;
  logic testing_c;

  assign mismatch_c = cmp_valid_q && (bist_dout != cmp_exp_q);
  assign start_ok_c = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign testing_c  = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_DRAIN);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wr_phase_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wr_phase_q <= wr_phase_d;
    end
  end

  // Next state: walk each element's address range, then hand over to the next element
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wr_phase_d = wr_phase_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_W0;
          addr_d     = ADDR_ZERO;
          wr_phase_d = 1'b0;
        end
      end
      S_W0: begin
        if (addr_q == ADDR_LAST) begin
          state_d = S_UP_R0W1;
          addr_d  = ADDR_ZERO;
        end else begin
          addr_d = addr_q + ADDR_WIDTH'(1);
        end
      end
      S_UP_R0W1, S_UP_R1W0: begin
        if (!wr_phase_q) begin
          wr_phase_d = 1'b1;
        end else begin
          wr_phase_d = 1'b0;
          if (addr_q == ADDR_LAST) begin
            state_d = (state_q == S_UP_R0W1) ? S_UP_R1W0 : S_DN_R0W1;
            addr_d  = (state_q == S_UP_R0W1) ? ADDR_ZERO : ADDR_LAST;
          end else begin
            addr_d = addr_q + ADDR_WIDTH'(1);
          end
        end
      end
      S_DN_R0W1, S_DN_R1W0: begin
        if (!wr_phase_q) begin
          wr_phase_d = 1'b1;
        end else begin
          wr_phase_d = 1'b0;
          if (addr_q == ADDR_ZERO) begin
            state_d = (state_q == S_DN_R0W1) ? S_DN_R1W0 : S_R0;
            addr_d  = (state_q == S_DN_R0W1) ? ADDR_LAST : ADDR_ZERO;
          end else begin
            addr_d = addr_q - ADDR_WIDTH'(1);
          end
        end
      end
      S_R0: begin
        if (addr_q == ADDR_LAST) begin
          state_d = S_DRAIN;
          addr_d  = ADDR_ZERO;
        end else begin
          addr_d = addr_q + ADDR_WIDTH'(1);
        end
      end
      S_DRAIN: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    // A mismatch lets the already-driven operation finish, then stops all access
    if (mismatch_c && testing_c) begin
      state_d    = S_DRAIN;
      addr_d     = ADDR_ZERO;
      wr_phase_d = 1'b0;
    end
  end

  // Output decode for the operation about to be driven (registered below)
  always_comb begin
    busy_d     = 1'b0;
    done_d     = 1'b0;
    wen_d      = 1'b0;
    ren_d      = 1'b0;
    din_d      = '0;
    exp_ones_d = 1'b0;
    case (state_d)
      S_W0: begin
        busy_d = 1'b1;
        wen_d  = 1'b1;
      end
      S_UP_R0W1, S_DN_R0W1: begin
        busy_d = 1'b1;
        if (wr_phase_d) begin
          wen_d = 1'b1;
          din_d = DATA_ONES;
        end else begin
          ren_d = 1'b1;
        end
      end
      S_UP_R1W0, S_DN_R1W0: begin
        busy_d = 1'b1;
        if (wr_phase_d) begin
          wen_d = 1'b1;
        end else begin
          ren_d      = 1'b1;
          exp_ones_d = 1'b1;
        end
      end
      S_R0: begin
        busy_d = 1'b1;
        ren_d  = 1'b1;
      end
      S_DRAIN: busy_d = 1'b1;
      S_DONE:  done_d = 1'b1;
      default: busy_d = 1'b0;
    endcase
    men_d   = wen_d | ren_d;
    bm_d    = wen_d ? DATA_ONES : '0;
    baddr_d = men_d ? addr_d : ADDR_ZERO;
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      en_q       <= 1'b0;
      men_q      <= 1'b0;
      wen_q      <= 1'b0;
      ren_q      <= 1'b0;
      baddr_q    <= '0;
      din_q      <= '0;
      bm_q       <= '0;
      exp_ones_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      done_q     <= done_d;
      en_q       <= busy_d;
      men_q      <= men_d;
      wen_q      <= wen_d;
      ren_q      <= ren_d;
      baddr_q    <= baddr_d;
      din_q      <= din_d;
      bm_q       <= bm_d;
      exp_ones_q <= exp_ones_d;
    end
  end

  // Compare pipeline: tag each read with its expectation, check it when data returns
  always_ff @(posedge clk) begin
    if (reset) begin
      cmp_valid_q <= 1'b0;
      cmp_exp_q   <= '0;
      cmp_addr_q  <= '0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else begin
      cmp_valid_q <= ren_q;
      cmp_exp_q   <= exp_ones_q ? DATA_ONES : '0;
      cmp_addr_q  <= baddr_q;
      if (start_ok_c) begin
        fail_q      <= 1'b0;
        fail_addr_q <= '0;
        fail_data_q <= '0;
      end else if (mismatch_c && !fail_q) begin
        fail_q      <= 1'b1;
        fail_addr_q <= cmp_addr_q;
        fail_data_q <= bist_dout;
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign fail      = fail_q;
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;
  assign bist_en   = en_q;
  assign bist_men  = men_q;
  assign bist_wen  = wen_q;
  assign bist_ren  = ren_q;
  assign bist_addr = baddr_q;
  assign bist_din  = din_q;
  assign bist_bm   = bm_q;

endmodule

// File: doc/sram_march_bist.md
Name: sram_march_bist

Overview:
- March C- built-in self-test engine for one single-port SG13G2 SRAM macro with byte-mask and BIST port.
- Sits directly upstream of the macro's BIST port. It drives the macro's BIST enable, BIST clock-domain controls, address, data and mask, and checks the macro's data output.
- Runs the full test on request, then reports pass/fail plus the first failing address and data word.
- Runs on the macro's clock.

Parameters:
- ADDR_WIDTH, 10, macro address width; N = 2^ADDR_WIDTH words.
- DATA_WIDTH, 32, macro data, byte-mask and data-output width.

Ports:
- clk  in  1  system clock; also routed to the macro BIST clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request; sampled only in IDLE or DONE.
- busy  out  1  test in progress.
- done  out  1  test finished; held until next start or reset.
- fail  out  1  mismatch detected; valid while done=1.
- fail_addr  out  ADDR_WIDTH  address of first mismatch.
- fail_data  out  DATA_WIDTH  read data at first mismatch.
- bist_en  out  1  to macro BIST enable; 1 while busy.
- bist_men  out  1  macro enable.
- bist_wen  out  1  write enable.
- bist_ren  out  1  read enable.
- bist_addr  out  ADDR_WIDTH  address.
- bist_din  out  DATA_WIDTH  write data.
- bist_bm  out  DATA_WIDTH  bit mask.
- bist_dout  in  DATA_WIDTH  macro read data, valid the cycle after a read.

Behaviour:
- One clock; reset is synchronous and active-high. Reset (including mid-test) returns to IDLE next edge. Every output is 0 after reset; no further macro access until the next start.
- All bus outputs are registered. bist_men = bist_wen | bist_ren. bist_bm is all-ones whenever bist_wen=1, else 0. bist_din is 0 when not writing. One operation per cycle, never read and write together.
- States and sequence (0/1 = all-zeros/all-ones background):
  - IDLE
  - W0: up, w0.
  - UP_R0W1: up, r0 then w1 per address.
  - UP_R1W0: up, r1 then w0.
  - DN_R0W1: down, r0 then w1.
  - DN_R1W0: down, r1 then w0.
  - R0: up, r0.
  - DRAIN
  - DONE
- Up = address 0..N-1; down = N-1..0. The address counter wraps at element boundaries only, and each element restarts at its start address.
- Timing:
  - start accepted at edge E0. busy=1 and the first operation (w0 @ addr 0) is driven in the cycle after E0.
  - Total 10N operation cycles, back to back, with no idle cycles between elements.
  - The last operation (r0 @ N-1) is in cycle 10N after E0.
  - DRAIN compares the last read. done=1 and busy=0 from cycle 10N+2 after E0.
- Compare pipeline:
  - Each read registers {expected, addr} alongside.
  - In the following cycle, bist_dout is compared with expected; the mismatch is registered at that edge.
  - Comparison uses the full DATA_WIDTH.
- On first mismatch:
  - fail_addr and fail_data are captured, fail=1.
  - The operation already driven in the compare cycle completes. After that, all enables are 0 and the FSM goes to DONE (done=1 one cycle after fail latches).
  - fail_* never change again until the next start.
- start:
  - While busy: ignored.
  - In DONE: clears done, fail, fail_addr and fail_data, and restarts exactly as from IDLE.
  - Asserted in the same cycle as reset: reset wins.
- bist_en drops to 0 in the same cycle as busy, so the functional port owns the macro outside tests.

Test Plan:
- Fault-free behavioural macro, ADDR_WIDTH=4, DATA_WIDTH=32: pulse start at E0.
  - Required: 160 back-to-back operations.
  - Required: first operation w0 @0 with bist_bm=0xFFFFFFFF; DN elements start at addr 15.
  - Required: done=1 and busy=0 exactly 162 cycles after E0; fail=0.
- Bit 3 of addr 5 forced stuck-at-1 in the model.
  - Required: fail=1, fail_addr=5, fail_data=0x00000008.
  - Required: the mismatch is detected in UP_R0W1; no enable asserted after w1 @5; done asserts the next cycle.
- Addr 9 forced stuck-at-0 on bit 31 for writes of 1 only.
  - Required: first fail in UP_R1W0 at addr 9, fail_data=0x7FFFFFFF.
- Reset asserted mid-test in DN_R0W1.
  - Required: next cycle all outputs 0 and state IDLE.
  - Required: a fresh start runs the full 162-cycle fault-free sequence.
- start pulsed again while busy, then again after a failing run.
  - Required: the busy pulse has no effect on the timeline.
  - Required: the pulse in DONE clears fail/done, and the rerun reports the same fail_addr/fail_data.
- Every cycle, assert the following:
  - bist_wen & bist_ren never both high.
  - bist_men == bist_wen | bist_ren.
  - bist_en == busy.
  - bist_bm == all-ones when bist_wen=1, else 0.
  - bist_din == 0 when not writing.
  - bist_addr stays within 0..N-1.
